// File: rtl/fft_wr_arbiter.sv
// Round-robin arbiter for the CCI-P c1 write channel shared by the FFT write requesters.
// It applies flow control, tracks outstanding writes and runs the job-end DSM completion write.

package fft_wr_arbiter_pkg;
   localparam int unsigned CL_ADDR_W = 42;
   localparam int unsigned CL_DATA_W = 512;
   localparam logic [31:0] HC_CONTROL_START = 32'h0000_0003;

   typedef logic [CL_ADDR_W-1:0] t_ccip_clAddr;
   typedef t_ccip_clAddr         t_hc_address;
   typedef logic [CL_DATA_W-1:0] t_ccip_clData;

   typedef enum logic [1:0] {
      eCL_LEN_1 = 2'b00,
      eCL_LEN_2 = 2'b01,
      eCL_LEN_4 = 2'b11
   } t_ccip_clLen;

   typedef enum logic [3:0] {
      eREQ_WRLINE_I = 4'h0,
      eREQ_WRLINE_M = 4'h1,
      eREQ_WRFENCE  = 4'h4
   } t_ccip_c1_req;

   typedef enum logic [3:0] {
      eRSP_WRLINE  = 4'h0,
      eRSP_WRFENCE = 4'h4
   } t_ccip_c1_rsp;

   typedef struct packed {
      logic [15:0]  mdata;
      t_ccip_clLen  cl_len;
      logic         sop;
      t_ccip_c1_req req_type;
      t_ccip_clAddr address;
   } t_ccip_c1_ReqMemHdr;

   typedef struct packed {
      t_ccip_c1_ReqMemHdr hdr;
      t_ccip_clData       data;
      logic               valid;
   } t_if_ccip_c1_Tx;

   typedef struct packed {
      logic [15:0]  mdata;
      t_ccip_c1_rsp resp_type;
   } t_ccip_c1_RspMemHdr;

   typedef struct packed {
      t_ccip_c1_RspMemHdr hdr;
      logic               rspValid;
   } t_if_ccip_c1_Rx;

   typedef struct packed {
      logic           c0TxAlmFull;
      logic           c1TxAlmFull;
      t_if_ccip_c1_Rx c1;
   } t_if_ccip_Rx;
endpackage

module fft_wr_arbiter
   import fft_wr_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ         = 2,
   parameter int unsigned MAX_OUTSTANDING = 64
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [31:0]                 hc_control,
   input  t_hc_address                 hc_dsm_base,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  t_ccip_clAddr [NUM_REQ-1:0]  req_addr,
   input  t_ccip_clData [NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]          req_grant,
   input  logic                        req_last,
   input  t_if_ccip_Rx                 ccip_rx,
   output t_if_ccip_c1_Tx              ccip_c1_tx,
   output logic [15:0]                 outstanding,
   output logic                        done
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned OUT_W = 16;
   localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_OUTSTANDING);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W+1)'(NUM_REQ);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DSM,
      S_WAIT,
      S_DONE
   } t_state;

   t_state           state, state_next;
   logic [IDX_W-1:0] rr, rr_next;
   logic [OUT_W-1:0] out_next;
   t_if_ccip_c1_Tx   tx_next;
   logic             done_next;

   logic             can_issue;
   logic             arb_en;
   logic             gnt_any;
   logic [IDX_W-1:0] gnt_idx;
   logic [IDX_W:0]   arb_idx;
   logic             wr_rsp;
   logic             issue;

   // Sideband fields of the rx bundle this block has no use for
   logic unused_ok;
   assign unused_ok = ^{ccip_rx.c0TxAlmFull, ccip_rx.c1.hdr.mdata};

   assign can_issue = !ccip_rx.c1TxAlmFull && (outstanding < MAX_OUT);
   assign arb_en    = (state == S_RUN) && can_issue;

   // Responses arriving with nothing outstanding are dropped rather than wrapping the count
   assign wr_rsp = ccip_rx.c1.rspValid && (ccip_rx.c1.hdr.resp_type == eRSP_WRLINE)
                   && (outstanding != '0);

   // Round-robin search: first valid requester at or after rr, wrapping to 0
   always_comb begin
      gnt_any   = 1'b0;
      gnt_idx   = '0;
      arb_idx   = '0;
      req_grant = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         arb_idx = {1'b0, rr} + (IDX_W+1)'(k);
         if (arb_idx >= NUM_EXT) begin
            arb_idx = arb_idx - NUM_EXT;
         end
         if (arb_en && !gnt_any && req_valid[arb_idx[IDX_W-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = arb_idx[IDX_W-1:0];
         end
      end
      if (gnt_any) begin
         req_grant[gnt_idx] = 1'b1;
      end
   end

   // Next-state, registered issue stage and counters
   always_comb begin
      state_next    = state;
      rr_next       = rr;
      tx_next       = ccip_c1_tx;
      tx_next.valid = 1'b0;
      issue         = 1'b0;
      out_next      = outstanding;
      done_next     = 1'b0;

      if (gnt_any) begin
         issue                  = 1'b1;
         tx_next.hdr.address    = req_addr[gnt_idx];
         tx_next.data           = req_data[gnt_idx];
         rr_next                = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
      end

      case (state)
         S_IDLE: begin
            if (hc_control == HC_CONTROL_START) begin
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (req_last && !gnt_any) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if ((outstanding == '0) && !ccip_c1_tx.valid) begin
               state_next = S_DSM;
            end
         end
         S_DSM: begin
            if (!ccip_rx.c1TxAlmFull) begin
               issue               = 1'b1;
               tx_next.hdr.address = hc_dsm_base;
               tx_next.data        = CL_DATA_W'(1);
               state_next          = S_WAIT;
            end
         end
         S_WAIT: begin
            if (outstanding == '0) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (hc_control != HC_CONTROL_START) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      if (issue) begin
         tx_next.valid        = 1'b1;
         tx_next.hdr.sop      = 1'b1;
         tx_next.hdr.cl_len   = eCL_LEN_1;
         tx_next.hdr.req_type = eREQ_WRLINE_I;
         tx_next.hdr.mdata    = '0;
      end

      case ({issue, wr_rsp})
         2'b10:   out_next = outstanding + OUT_W'(1);
         2'b01:   out_next = outstanding - OUT_W'(1);
         default: out_next = outstanding;
      endcase

      done_next = (state_next == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         rr          <= '0;
         outstanding <= '0;
         ccip_c1_tx  <= '0;
         done        <= 1'b0;
      end else begin
         state       <= state_next;
         rr          <= rr_next;
         outstanding <= out_next;
         ccip_c1_tx  <= tx_next;
         done        <= done_next;
      end
   end

endmodule
